// File: rtl/draw_scheduler.sv
// Frame-level arbiter for the shared VGA plot path: runs the self datapath, then the enemy
// datapath, once per frame tick, with a per-phase watchdog and single-deep tick queueing.
module draw_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic enemy_enable,
    input  logic self_done,
    input  logic enemy_done,
    output logic self_go,
    output logic enemy_go,
    output logic datapath_select,
    output logic plot_en,
    output logic busy,
    output logic frame_drop,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        SELF_GO,
        SELF_WAIT,
        ENEMY_GO,
        ENEMY_WAIT
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        pending, pending_next;
    logic [15:0] counter, counter_next;
    logic        frame_drop_next;
    logic        timeout_err_next;
    logic        timed_out;

    assign timed_out = (counter == LAST_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            counter     <= 16'd0;
            frame_drop  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            counter     <= counter_next;
            frame_drop  <= frame_drop_next;
            timeout_err <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        pending_next     = pending;
        counter_next     = counter;
        frame_drop_next  = 1'b0;
        timeout_err_next = timeout_err;

        // Only one frame can be queued behind the one being drawn; further ticks are dropped.
        if (state != IDLE && frame_tick) begin
            if (pending) begin
                frame_drop_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (frame_tick || pending) begin
                    state_next   = SELF_GO;
                    pending_next = 1'b0;
                end
            end
            SELF_GO: begin
                counter_next = 16'd0;
                state_next   = SELF_WAIT;
            end
            SELF_WAIT: begin
                counter_next = counter + 16'd1;
                if (self_done || timed_out) begin
                    if (!self_done) begin
                        timeout_err_next = 1'b1;
                    end
                    state_next = enemy_enable ? ENEMY_GO : IDLE;
                end
            end
            ENEMY_GO: begin
                counter_next = 16'd0;
                state_next   = ENEMY_WAIT;
            end
            ENEMY_WAIT: begin
                counter_next = counter + 16'd1;
                if (enemy_done || timed_out) begin
                    if (!enemy_done) begin
                        timeout_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign self_go         = (state == SELF_GO);
    assign enemy_go        = (state == ENEMY_GO);
    assign datapath_select = (state == ENEMY_GO) || (state == ENEMY_WAIT);
    assign plot_en         = (state != IDLE);
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomised and directed bench for draw_scheduler: a frame-level reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_draw_scheduler;

    localparam int unsigned TMO = 12;

    logic clk;
    logic reset;
    logic frame_tick;
    logic enemy_enable;
    logic self_done;
    logic enemy_done;
    logic self_go;
    logic enemy_go;
    logic datapath_select;
    logic plot_en;
    logic busy;
    logic frame_drop;
    logic timeout_err;

    draw_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .enemy_enable    (enemy_enable),
        .self_done       (self_done),
        .enemy_done      (enemy_done),
        .self_go         (self_go),
        .enemy_go        (enemy_go),
        .datapath_select (datapath_select),
        .plot_en         (plot_en),
        .busy            (busy),
        .frame_drop      (frame_drop),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the plot path, whether this is its start cycle, how long it
    // has been drawing, and whether another frame is waiting behind it.
    int owner;      // 0 nobody, 1 self, 2 enemy
    bit starting;
    int drawn;
    bit queued;
    bit dropped;
    bit timed_out_ever;

    logic [6:0] sb[$];
    int n_compared;
    int n_mismatched;
    bit cur_en;

    task automatic modelReset();
        owner          = 0;
        starting       = 1'b0;
        drawn          = 0;
        queued         = 1'b0;
        dropped        = 1'b0;
        timed_out_ever = 1'b0;
    endtask

    task automatic modelStep(input bit tick, input bit en, input bit sd, input bit ed);
        bit finished;
        bit expired;
        dropped = 1'b0;
        if (owner == 0) begin
            if (tick || queued) begin
                owner    = 1;
                starting = 1'b1;
                queued   = 1'b0;
            end
        end else begin
            if (tick) begin
                if (queued) dropped = 1'b1;
                else queued = 1'b1;
            end
            if (starting) begin
                starting = 1'b0;
                drawn    = 0;
            end else begin
                finished = (owner == 1) ? sd : ed;
                expired  = (drawn + 1 >= int'(TMO));
                if (finished || expired) begin
                    if (!finished) timed_out_ever = 1'b1;
                    if (owner == 1 && en) begin
                        owner    = 2;
                        starting = 1'b1;
                    end else begin
                        owner = 0;
                    end
                end else begin
                    drawn = drawn + 1;
                end
            end
        end
    endtask

    function automatic logic [6:0] modelOutputs();
        return {owner == 1 && starting, owner == 2 && starting, owner == 2,
                owner != 0, owner != 0, dropped, timed_out_ever};
    endfunction

    // One clock cycle: advance model on the edge with the inputs it saw, then drive new inputs.
    task automatic applyStimulus(input bit tick, input bit en, input bit sd, input bit ed,
                                 input bit rst);
        @(posedge clk);
        if (reset) modelReset();
        else modelStep(frame_tick, enemy_enable, self_done, enemy_done);
        #1;
        frame_tick   = tick;
        enemy_enable = en;
        self_done    = sd;
        enemy_done   = ed;
        reset        = rst;
        if (rst) modelReset();
        sb.push_back(modelOutputs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, cur_en, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input logic [6:0] expected);
        logic [6:0] actual;
        actual = {self_go, enemy_go, datapath_select, plot_en, busy, frame_drop, timeout_err};
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL outputs t=%0t got go_s/go_e/sel/plot/busy/drop/terr=%b want %b",
                     $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cur_en       = 1'b1;
        reset        = 1'b1;
        frame_tick   = 1'b0;
        enemy_enable = 1'b1;
        self_done    = 1'b0;
        enemy_done   = 1'b0;
        modelReset();

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);

        $display("[TB] full frame with both phases");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);

        $display("[TB] enemy phase skipped");
        cur_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        cur_en = 1'b1;

        $display("[TB] spurious done pulses");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        $display("[TB] queued tick, dropped tick, tick on last done");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(6);

        $display("[TB] watchdog timeouts");
        idle(2 * TMO + 6);

        $display("[TB] reset in enemy phase with a queued frame");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 599) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain leftover=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
